button_pulse_gen: RTL and testbench
===================================

# button_pulse_gen

Conditions the two raw current-selection push-buttons (up/down) into clean, single-cycle command pulses for the current-selection counter. Each button passes through a 2-flop synchronizer and a debouncer. It then passes through a press/hold state machine that emits one pulse per press, plus optional auto-repeat while the button is held. Sits between the board pins and the counter's up/down inputs, in the same clk domain as the counter.

## Interface
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a level change (≥2).
- REPEAT_DELAY, default 25000000: cycles held after first pulse before auto-repeat starts; 0 disables auto-repeat.
- REPEAT_RATE, default 10000000: cycles between auto-repeat pulses (≥2).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  enables pulse generation; debouncing always runs.
- btn_up_raw  in  1  raw asynchronous up button, active-high.
- btn_down_raw  in  1  raw asynchronous down button, active-high.
- up_pulse  out  1  one-cycle increment command.
- down_pulse  out  1  one-cycle decrement command.
- up_level  out  1  debounced up level (status/LED).
- down_level  out  1  debounced down level.

## Operation
- Per channel: sync1→sync2 flops, then debouncer, then FSM. The two channels are identical and independent except for the conflict rule.
- Debouncer: counter clears whenever sync2 equals the stable level. It increments while they differ. When it reaches DEBOUNCE_CYCLES-1 while still differing, the stable level flips and the counter clears. Counter width is $clog2(DEBOUNCE_CYCLES).
- FSM states: IDLE, FIRST, DELAY, REPEAT.
  - IDLE → FIRST on a stable rising edge with en=1.
  - FIRST: pulse high for this single cycle → DELAY (or → WAIT_REL behaviour: remain in DELAY with the timer frozen if REPEAT_DELAY=0).
  - DELAY: timer counts to REPEAT_DELAY-1 → REPEAT, emitting one pulse on the transition cycle.
  - REPEAT: timer counts to REPEAT_RATE-1, emits one pulse and restarts.
  - Any state → IDLE when the stable level falls or en=0.
- Timer width is $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1). The timer is shared by DELAY and REPEAT and cleared on every state entry.
- A press requires a rising edge. A button already held when en rises, or held through reset release, produces no pulse until it is released and pressed again.
- Conflict: while both stable levels are high, up_pulse and down_pulse are both forced 0 and both FSMs return to IDLE. Releasing one button does not generate a pulse for the other without a fresh press.
- up_pulse and down_pulse are never high in the same cycle.

## Timing
- Reset values: all sync flops, stable levels, counters, timers = 0; FSMs = IDLE; all outputs = 0.
- Press latency: raw high first sampled at edge 1 → up_level high after edge DEBOUNCE_CYCLES+2 → up_pulse high for the cycle after edge DEBOUNCE_CYCLES+3.
- Release latency: level falls DEBOUNCE_CYCLES+2 edges after raw falls; no pulse on release.
- Glitches shorter than DEBOUNCE_CYCLES cycles (after sync) are fully rejected.
- Auto-repeat: second pulse REPEAT_DELAY+1 cycles after the first pulse, then one every REPEAT_RATE cycles.
- Outputs are registered; no combinational path from inputs to outputs.
- Asynchronous rst mid-press clears everything immediately. Pulses resume only on a new debounced press after release.

## Structure
- Shared package: FSM state enum (IDLE, FIRST, DELAY, REPEAT) and a clog2-based width helper constant function.
- Sub-module button_debounce (sync + debounce, parameter DEBOUNCE_CYCLES, outputs stable level and rise strobe), instantiated twice.
- The FSMs, timers and conflict logic live in the top module.

## Test plan
All cases use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
- Clean press of btn_up_raw for 10 cycles, en=1 → exactly one up_pulse, one cycle wide, in the cycle after edge 7; down_pulse stays 0.
- btn_down_raw bounce (1,0,1,0 every cycle for 6 cycles, then steady 1 for 12 cycles) → exactly one down_pulse, timed from the start of the steady level.
- Hold btn_up_raw for 60 cycles → pulses at first-pulse cycle t, then t+21, t+29, t+37, t+45, t+53; none after release.
- Both buttons held together, then up released → no pulses on either output at any time.
- Button held while en=0, then en raised with the button still held → no pulse; release and re-press → one pulse.
- rst asserted asynchronously during auto-repeat → all outputs 0 immediately; held button after rst release gives no pulse until re-pressed.

Source files
------------

// File: rtl/button_pulse_gen_pkg.sv
// Shared types and helpers for the push-button pulse generator.
// Holds the press/hold FSM encoding, channel indices and a counter-width helper.
package button_pulse_gen_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFirst,
        StDelay,
        StRepeat
    } btn_state_e;

    localparam int unsigned NumChannels = 2;
    localparam int unsigned ChUp        = 0;
    localparam int unsigned ChDown      = 1;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int unsigned width_for(input int unsigned value);
        int unsigned w;
        w = (value > 2) ? int'($clog2(value)) : 1;
        return w;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw button input.
// Produces the debounced level and a one-cycle strobe on accepted presses.
module button_debounce
    import button_pulse_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CntW = width_for(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            prime0_q, prime1_q;
    logic            armed_q, armed_d;
    logic            rise_q, rise_d;
    logic            differ, flip;

    always_comb begin
        differ   = (sync2_q != stable_q);
        flip     = differ && (cnt_q == CntLast);
        cnt_d    = (differ && !flip) ? cnt_q + CntW'(1) : '0;
        stable_d = flip ? ~stable_q : stable_q;
        // A button held through reset must be seen released before a press counts.
        armed_d  = armed_q | (prime1_q & ~sync2_q & ~stable_q);
        rise_d   = flip & ~stable_q & armed_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            prime0_q <= 1'b0;
            prime1_q <= 1'b0;
            armed_q  <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            prime0_q <= 1'b1;
            prime1_q <= prime0_q;
            armed_q  <= armed_d;
            rise_q   <= rise_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Turns the raw up/down current-selection buttons into single-cycle counter commands,
// with one pulse per press, optional auto-repeat while held and mutual-exclusion on conflict.
module button_pulse_gen
    import button_pulse_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic up_pulse,
    output logic down_pulse,
    output logic up_level,
    output logic down_level
);

    localparam int unsigned MaxSpan  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TimerW   = width_for(MaxSpan + 1);
    localparam bit          RepeatEn = (REPEAT_DELAY != 0);
    localparam logic [TimerW-1:0] DelayLast = TimerW'(REPEAT_DELAY - 1);
    localparam logic [TimerW-1:0] RateLast  = TimerW'(REPEAT_RATE - 1);

    logic [NumChannels-1:0] level;
    logic [NumChannels-1:0] rise;
    logic [NumChannels-1:0] pulse_q, pulse_d;
    logic                   conflict;

    btn_state_e        state_q [NumChannels];
    btn_state_e        state_d [NumChannels];
    logic [TimerW-1:0] timer_q [NumChannels];
    logic [TimerW-1:0] timer_d [NumChannels];

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_up (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_up_raw),
        .level(level[ChUp]),
        .rise (rise[ChUp])
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_down (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_down_raw),
        .level(level[ChDown]),
        .rise (rise[ChDown])
    );

    always_comb begin
        conflict = level[ChUp] & level[ChDown];
        pulse_d  = '0;
        for (int unsigned ch = 0; ch < NumChannels; ch++) begin
            state_d[ch] = state_q[ch];
            timer_d[ch] = timer_q[ch];
            if (!en || conflict || !level[ch]) begin
                state_d[ch] = StIdle;
                timer_d[ch] = '0;
            end else begin
                unique case (state_q[ch])
                    StIdle: begin
                        if (rise[ch]) begin
                            state_d[ch] = StFirst;
                            pulse_d[ch] = 1'b1;
                        end
                    end
                    StFirst: begin
                        state_d[ch] = StDelay;
                        timer_d[ch] = '0;
                    end
                    StDelay: begin
                        // With auto-repeat disabled this state just waits for release.
                        if (RepeatEn) begin
                            if (timer_q[ch] == DelayLast) begin
                                state_d[ch] = StRepeat;
                                timer_d[ch] = '0;
                                pulse_d[ch] = 1'b1;
                            end else begin
                                timer_d[ch] = timer_q[ch] + TimerW'(1);
                            end
                        end
                    end
                    StRepeat: begin
                        if (timer_q[ch] == RateLast) begin
                            timer_d[ch] = '0;
                            pulse_d[ch] = 1'b1;
                        end else begin
                            timer_d[ch] = timer_q[ch] + TimerW'(1);
                        end
                    end
                    default: begin
                        state_d[ch] = StIdle;
                        timer_d[ch] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= '0;
            for (int unsigned ch = 0; ch < NumChannels; ch++) begin
                state_q[ch] <= StIdle;
                timer_q[ch] <= '0;
            end
        end else begin
            pulse_q <= pulse_d;
            for (int unsigned ch = 0; ch < NumChannels; ch++) begin
                state_q[ch] <= state_d[ch];
                timer_q[ch] <= timer_d[ch];
            end
        end
    end

    // Masking with the registered levels keeps both commands low in any cycle both buttons read held.
    assign up_pulse   = pulse_q[ChUp] & ~conflict;
    assign down_pulse = pulse_q[ChDown] & ~conflict;
    assign up_level   = level[ChUp];
    assign down_level = level[ChDown];

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen: a press/hold event model checked every cycle,
// plus literal pulse counts and timings for each directed scenario.
module tb_button_pulse_gen;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic btn_up_raw;
    logic btn_down_raw;
    logic up_pulse, down_pulse, up_level, down_level;

    button_pulse_gen #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .btn_up_raw  (btn_up_raw),
        .btn_down_raw(btn_down_raw),
        .up_pulse    (up_pulse),
        .down_pulse  (down_pulse),
        .up_level    (up_level),
        .down_level  (down_level)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit checking = 1'b0;

    int up_count = 0;
    int down_count = 0;
    int up_times[$];
    int down_times[$];

    // Model state: raw sample history, debounced level, arming and press session age.
    bit hist [2][0:D+1];
    int n_edges;
    bit m_lvl [2];
    bit m_armed [2];
    bit m_rise [2];
    bit m_active [2];
    int m_age [2];
    bit exp_pulse [2];

    task automatic chk(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic model_clear();
        n_edges = 0;
        for (int ch = 0; ch < 2; ch++) begin
            for (int k = 0; k <= D + 1; k++) hist[ch][k] = 1'b0;
            m_lvl[ch] = 1'b0;
            m_armed[ch] = 1'b0;
            m_rise[ch] = 1'b0;
            m_active[ch] = 1'b0;
            m_age[ch] = 0;
            exp_pulse[ch] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit conf_p;
        bit pn [2];
        bit raw_s [2];
        bit flip;
        raw_s[0] = btn_up_raw;
        raw_s[1] = btn_down_raw;
        conf_p = m_lvl[0] && m_lvl[1];
        n_edges++;
        for (int ch = 0; ch < 2; ch++) begin
            // Pulse for the coming cycle is decided by the cycle that just ended.
            pn[ch] = 1'b0;
            if (!en || !m_lvl[ch] || conf_p) begin
                m_active[ch] = 1'b0;
            end else if (!m_active[ch]) begin
                if (m_rise[ch]) begin
                    m_active[ch] = 1'b1;
                    m_age[ch] = 0;
                    pn[ch] = 1'b1;
                end
            end else begin
                m_age[ch]++;
                pn[ch] = (m_age[ch] >= RD + 1) && (((m_age[ch] - RD - 1) % RR) == 0);
            end
            for (int k = D + 1; k >= 1; k--) hist[ch][k] = hist[ch][k-1];
            hist[ch][0] = raw_s[ch];
            // Level flips once the last D synchronized samples all disagree with it.
            flip = 1'b1;
            for (int k = 2; k <= D + 1; k++) if (hist[ch][k] == m_lvl[ch]) flip = 1'b0;
            m_rise[ch] = flip && !m_lvl[ch] && m_armed[ch];
            if (n_edges >= 3 && !hist[ch][2] && !m_lvl[ch]) m_armed[ch] = 1'b1;
            if (flip) m_lvl[ch] = !m_lvl[ch];
        end
        for (int ch = 0; ch < 2; ch++) exp_pulse[ch] = pn[ch] && !(m_lvl[0] && m_lvl[1]);
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_clear();
            else model_step();
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (checking) begin
            chk("up_pulse", up_pulse, exp_pulse[0]);
            chk("down_pulse", down_pulse, exp_pulse[1]);
            chk("up_level", up_level, m_lvl[0]);
            chk("down_level", down_level, m_lvl[1]);
            if (up_pulse === 1'b1) begin
                up_count++;
                up_times.push_back(cyc);
            end
            if (down_pulse === 1'b1) begin
                down_count++;
                down_times.push_back(cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_log();
        up_count = 0;
        down_count = 0;
        up_times.delete();
        down_times.delete();
    endtask

    function automatic int first_up(input int base);
        return (up_times.size() > 0) ? up_times[0] - base : -1;
    endfunction

    int p;
    int exp_off [6] = '{7, 28, 36, 44, 52, 60};

    initial begin
        rst = 1'b1;
        en = 1'b0;
        btn_up_raw = 1'b0;
        btn_down_raw = 1'b0;
        tick(2);
        checking = 1'b1;
        chk("reset_up_pulse", up_pulse, 1'b0);
        chk("reset_down_pulse", down_pulse, 1'b0);
        chk("reset_up_level", up_level, 1'b0);
        chk("reset_down_level", down_level, 1'b0);
        rst = 1'b0;
        en = 1'b1;
        tick(5);

        // Clean up press.
        clear_log();
        p = cyc;
        btn_up_raw = 1'b1;
        tick(10);
        btn_up_raw = 1'b0;
        tick(15);
        chk_int("clean_up_count", up_count, 1);
        chk_int("clean_up_time", first_up(p), 7);
        chk_int("clean_down_count", down_count, 0);

        // Bouncing down press.
        clear_log();
        for (int i = 0; i < 6; i++) begin
            btn_down_raw = (i % 2 == 0);
            tick(1);
        end
        p = cyc;
        btn_down_raw = 1'b1;
        tick(12);
        btn_down_raw = 1'b0;
        tick(15);
        chk_int("bounce_down_count", down_count, 1);
        chk_int("bounce_down_time", (down_times.size() > 0) ? down_times[0] - p : -1, 7);
        chk_int("bounce_up_count", up_count, 0);

        // Long hold with auto-repeat.
        clear_log();
        p = cyc;
        btn_up_raw = 1'b1;
        tick(60);
        btn_up_raw = 1'b0;
        tick(20);
        chk_int("repeat_up_count", up_count, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < up_times.size()) chk_int("repeat_up_time", up_times[i] - p, exp_off[i]);
        end

        // Both held together, then up released first.
        clear_log();
        btn_up_raw = 1'b1;
        btn_down_raw = 1'b1;
        tick(20);
        btn_up_raw = 1'b0;
        tick(15);
        btn_down_raw = 1'b0;
        tick(15);
        chk_int("conflict_up_count", up_count, 0);
        chk_int("conflict_down_count", down_count, 0);

        // Held while disabled, then enabled while still held.
        clear_log();
        en = 1'b0;
        btn_up_raw = 1'b1;
        tick(15);
        en = 1'b1;
        tick(15);
        chk_int("en_held_up_count", up_count, 0);
        btn_up_raw = 1'b0;
        tick(12);
        p = cyc;
        btn_up_raw = 1'b1;
        tick(10);
        btn_up_raw = 1'b0;
        tick(15);
        chk_int("en_repress_up_count", up_count, 1);
        chk_int("en_repress_up_time", first_up(p), 7);

        // Asynchronous reset during auto-repeat.
        clear_log();
        p = cyc;
        btn_up_raw = 1'b1;
        tick(33);
        chk_int("pre_rst_up_count", up_count, 2);
        chk("pre_rst_up_level", up_level, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_up_level", up_level, 1'b0);
        chk("rst_async_up_pulse", up_pulse, 1'b0);
        chk("rst_async_down_pulse", down_pulse, 1'b0);
        tick(3);
        rst = 1'b0;
        clear_log();
        tick(25);
        chk("held_after_rst_level", up_level, 1'b1);
        chk_int("held_after_rst_count", up_count, 0);
        btn_up_raw = 1'b0;
        tick(12);
        p = cyc;
        btn_up_raw = 1'b1;
        tick(10);
        btn_up_raw = 1'b0;
        tick(15);
        chk_int("rst_repress_up_count", up_count, 1);
        chk_int("rst_repress_up_time", first_up(p), 7);
        chk_int("rst_repress_down_count", down_count, 0);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
